// File: rtl/lives_controller_if.sv
// Handshake bundle between the lives controller and its neighbours:
// collision/start/frame inputs in, lives and graphics enables out.
interface lives_controller_if #(
  parameter int MAX_LIVES = 2
);
  logic                 start;
  logic                 hit;
  logic                 frame_tick;
  logic [1:0]           lives;
  logic [MAX_LIVES-1:0] heart_en;
  logic                 player_en;
  logic                 game_over;
  logic                 invuln;

  modport master (
    output start, hit, frame_tick,
    input  lives, heart_en, player_en, game_over, invuln
  );

  modport slave (
    input  start, hit, frame_tick,
    output lives, heart_en, player_en, game_over, invuln
  );
endinterface

// File: rtl/lives_controller.sv
// Player lives sequencer: start, hit edge detection, invulnerability
// window with heart blink, game over; all outputs registered.
module lives_controller #(
  parameter int MAX_LIVES     = 2,
  parameter int INVULN_FRAMES = 90,
  parameter int BLINK_FRAMES  = 8
) (
  input logic               clk,
  input logic               reset_n,
  lives_controller_if.slave bus
);
  localparam int IW = $clog2(INVULN_FRAMES + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  localparam logic [1:0]    MAX_L  = 2'(MAX_LIVES);
  localparam logic [IW-1:0] INV_LD = IW'(INVULN_FRAMES);
  localparam logic [IW-1:0] INV_1  = IW'(1);
  localparam logic [BW-1:0] BLK_LS = BW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    INVULN = 2'd2,
    OVER   = 2'd3
  } state_t;

  state_t               r_state;
  logic [1:0]           r_lives;
  logic [MAX_LIVES-1:0] r_heart_en;
  logic                 r_player_en;
  logic                 r_game_over;
  logic                 r_invuln;
  logic [IW-1:0]        r_inv_cnt;
  logic [BW-1:0]        r_blink_cnt;
  logic                 r_blink_ph;
  logic                 r_hit_q;

  state_t               w_state;
  logic [1:0]           w_lives;
  logic [MAX_LIVES-1:0] w_heart_en;
  logic [IW-1:0]        w_inv_cnt;
  logic [BW-1:0]        w_blink_cnt;
  logic                 w_blink_ph;
  logic                 w_hit_rise;
  logic                 w_dim;

  assign w_hit_rise = bus.hit & ~r_hit_q;

  always_comb begin
    w_state     = r_state;
    w_lives     = r_lives;
    w_inv_cnt   = r_inv_cnt;
    w_blink_cnt = r_blink_cnt;
    w_blink_ph  = r_blink_ph;
    // start outranks everything, including a coincident hit
    if (bus.start) begin
      w_state     = PLAY;
      w_lives     = MAX_L;
      w_inv_cnt   = '0;
      w_blink_cnt = '0;
      w_blink_ph  = 1'b0;
    end else begin
      case (r_state)
        IDLE: ;
        PLAY: begin
          if (w_hit_rise) begin
            if (r_lives > 2'd1) begin
              w_state     = INVULN;
              w_lives     = r_lives - 2'd1;
              w_inv_cnt   = INV_LD;
              w_blink_cnt = '0;
              w_blink_ph  = 1'b0;
            end else begin
              w_state = OVER;
              w_lives = 2'd0;
            end
          end
        end
        INVULN: begin
          if (bus.frame_tick) begin
            if (r_inv_cnt == INV_1) begin
              w_state     = PLAY;
              w_inv_cnt   = '0;
              w_blink_cnt = '0;
              w_blink_ph  = 1'b0;
            end else begin
              w_inv_cnt = r_inv_cnt - INV_1;
              if (r_blink_cnt == BLK_LS) begin
                w_blink_cnt = '0;
                w_blink_ph  = ~r_blink_ph;
              end else begin
                w_blink_cnt = r_blink_cnt + BW'(1);
              end
            end
          end
        end
        OVER: ;
        default: begin
          w_state = IDLE;
          w_lives = 2'd0;
        end
      endcase
    end
  end

  assign w_dim = (w_state == INVULN) & w_blink_ph;

  always_comb begin
    w_heart_en = '0;
    for (int i = 0; i < MAX_LIVES; i++) begin
      w_heart_en[i] = (i < int'(w_lives)) & ~w_dim;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_lives     <= 2'd0;
      r_heart_en  <= '0;
      r_player_en <= 1'b0;
      r_game_over <= 1'b0;
      r_invuln    <= 1'b0;
      r_inv_cnt   <= '0;
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
      r_hit_q     <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_lives     <= w_lives;
      r_heart_en  <= w_heart_en;
      r_player_en <= (w_state == PLAY) | (w_state == INVULN);
      r_game_over <= (w_state == OVER);
      r_invuln    <= (w_state == INVULN);
      r_inv_cnt   <= w_inv_cnt;
      r_blink_cnt <= w_blink_cnt;
      r_blink_ph  <= w_blink_ph;
      r_hit_q     <= bus.hit;
    end
  end

  assign bus.lives     = r_lives;
  assign bus.heart_en  = r_heart_en;
  assign bus.player_en = r_player_en;
  assign bus.game_over = r_game_over;
  assign bus.invuln    = r_invuln;
endmodule
